// File: rtl/conv_loop_sequencer.sv
// Loop-nest sequencer for one conv layer: walks oy1/ox1/oc1/ic1/fy/fx/oy0/ox0
// and emits ifmap/weight/accum buffer addresses with bank handshakes.
module conv_loop_sequencer #(
    parameter int PARAM_WID       = 16,
    parameter int PARAM_NUM       = 9,
    parameter int BANK_ADDR_WIDTH = 32,
    parameter int DRAIN_CYCLES    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PARAM_NUM*PARAM_WID-1:0] params_dat,
    input  logic                           params_vld,
    output logic                           params_rdy,
    input  logic                           ifmap_bank_vld,
    input  logic                           weight_bank_vld,
    input  logic                           accum_bank_free,
    output logic                           ifmap_bank_done,
    output logic                           weight_bank_done,
    output logic                           accum_bank_done,
    output logic                           step_vld,
    input  logic                           step_rdy,
    output logic [BANK_ADDR_WIDTH-1:0]     ifmap_addr,
    output logic [BANK_ADDR_WIDTH-1:0]     weight_addr,
    output logic [BANK_ADDR_WIDTH-1:0]     accum_addr,
    output logic                           accum_zero,
    output logic                           layer_done,
    output logic                           layer_err
);

    localparam int PW = PARAM_WID;
    localparam int AW = BANK_ADDR_WIDTH;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_WAIT, S_RUN, S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [PARAM_NUM*PW-1:0] params_q, params_d;
    logic [AW-1:0] ix0_q, ix0_d, plane_q, plane_d, row_step_q, row_step_d;
    logic [PW-1:0] ox0_q, ox0_d, oy0_q, oy0_d, fx_q, fx_d, fy_q, fy_d;
    logic [PW-1:0] ic1_q, ic1_d, oc1_q, oc1_d, ox1_q, ox1_d, oy1_q, oy1_d;
    logic [AW-1:0] ox_off_q, ox_off_d, oy_off_q, oy_off_d;
    logic [AW-1:0] fy_base_q, fy_base_d, ic_base_q, ic_base_d;
    logic [AW-1:0] ifmap_q, ifmap_d, weight_q, weight_d, accum_q, accum_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          need_ifmap_q, need_ifmap_d, need_weight_q, need_weight_d;

    logic [PW-1:0] p_s, p_ox0, p_oy0, p_fx, p_fy, p_ic1, p_oc1, p_ox1, p_oy1;
    assign p_s   = params_q[0*PW +: PW];
    assign p_ox0 = params_q[1*PW +: PW];
    assign p_oy0 = params_q[2*PW +: PW];
    assign p_fx  = params_q[3*PW +: PW];
    assign p_fy  = params_q[4*PW +: PW];
    assign p_ic1 = params_q[5*PW +: PW];
    assign p_oc1 = params_q[6*PW +: PW];
    assign p_ox1 = params_q[7*PW +: PW];
    assign p_oy1 = params_q[8*PW +: PW];

    logic          any_zero;
    logic [AW-1:0] s_w, iy0_c, ix0_c, plane_c, row_c;

    assign any_zero = (p_s == '0) || (p_ox0 == '0) || (p_oy0 == '0) ||
                      (p_fx == '0) || (p_fy == '0) || (p_ic1 == '0) ||
                      (p_oc1 == '0) || (p_ox1 == '0) || (p_oy1 == '0);
    // Geometry products only feed config-time registers; per-step logic is adders.
    assign s_w     = AW'(p_s);
    assign iy0_c   = s_w * (AW'(p_oy0) - AW'(1)) + AW'(p_fy);
    assign ix0_c   = s_w * (AW'(p_ox0) - AW'(1)) + AW'(p_fx);
    assign plane_c = iy0_c * ix0_c;
    assign row_c   = s_w * ix0_c;

    logic ox0_last, oy0_last, fx_last, fy_last, ic1_last;
    logic oc1_last, ox1_last, oy1_last, tile_last, inner_last, pass_last;
    logic fire, drain_end, bank_go;

    assign ox0_last   = ox0_q == p_ox0 - PW'(1);
    assign oy0_last   = oy0_q == p_oy0 - PW'(1);
    assign fx_last    = fx_q == p_fx - PW'(1);
    assign fy_last    = fy_q == p_fy - PW'(1);
    assign ic1_last   = ic1_q == p_ic1 - PW'(1);
    assign oc1_last   = oc1_q == p_oc1 - PW'(1);
    assign ox1_last   = ox1_q == p_ox1 - PW'(1);
    assign oy1_last   = oy1_q == p_oy1 - PW'(1);
    assign tile_last  = ox1_last && oy1_last;
    assign inner_last = ox0_last && oy0_last;
    assign pass_last  = inner_last && fx_last && fy_last && ic1_last;

    assign fire      = (state_q == S_RUN) && step_rdy;
    assign drain_end = (state_q == S_DRAIN) &&
                       (drain_q == DW'(DRAIN_CYCLES - 1));
    assign bank_go   = accum_bank_free &&
                       (!need_ifmap_q || ifmap_bank_vld) &&
                       (!need_weight_q || weight_bank_vld);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (params_vld) state_d = S_CONFIG;
            S_CONFIG: state_d = any_zero ? S_IDLE : S_WAIT;
            S_WAIT:   if (bank_go) state_d = S_RUN;
            S_RUN:    if (fire && pass_last) state_d = S_DRAIN;
            S_DRAIN:  if (drain_end)
                          state_d = (oc1_last && tile_last) ? S_IDLE : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        params_rdy       = state_q == S_IDLE;
        layer_err        = (state_q == S_CONFIG) && any_zero;
        step_vld         = state_q == S_RUN;
        accum_bank_done  = drain_end;
        ifmap_bank_done  = drain_end && oc1_last;
        weight_bank_done = drain_end && oc1_last && tile_last;
        layer_done       = drain_end && oc1_last && tile_last;
        accum_zero       = step_vld && (ic1_q == '0) &&
                           (fy_q == '0) && (fx_q == '0);
        ifmap_addr       = ifmap_q;
        weight_addr      = weight_q;
        accum_addr       = accum_q;
    end

    always_comb begin
        params_d      = params_q;
        ix0_d         = ix0_q;
        plane_d       = plane_q;
        row_step_d    = row_step_q;
        ox0_d         = ox0_q;
        oy0_d         = oy0_q;
        fx_d          = fx_q;
        fy_d          = fy_q;
        ic1_d         = ic1_q;
        oc1_d         = oc1_q;
        ox1_d         = ox1_q;
        oy1_d         = oy1_q;
        ox_off_d      = ox_off_q;
        oy_off_d      = oy_off_q;
        fy_base_d     = fy_base_q;
        ic_base_d     = ic_base_q;
        weight_d      = weight_q;
        accum_d       = accum_q;
        drain_d       = drain_q;
        need_ifmap_d  = need_ifmap_q;
        need_weight_d = need_weight_q;

        if (state_q == S_IDLE && params_vld) params_d = params_dat;

        if (state_q == S_CONFIG) begin
            ix0_d         = ix0_c;
            plane_d       = plane_c;
            row_step_d    = row_c;
            ox0_d         = '0;
            oy0_d         = '0;
            fx_d          = '0;
            fy_d          = '0;
            ic1_d         = '0;
            oc1_d         = '0;
            ox1_d         = '0;
            oy1_d         = '0;
            ox_off_d      = '0;
            oy_off_d      = '0;
            fy_base_d     = '0;
            ic_base_d     = '0;
            weight_d      = '0;
            accum_d       = '0;
            drain_d       = '0;
            need_ifmap_d  = 1'b1;
            need_weight_d = 1'b1;
        end

        if (state_q == S_WAIT && bank_go) begin
            need_ifmap_d  = 1'b0;
            need_weight_d = 1'b0;
        end

        // Weight index is linear in (oc1,ic1,fy,fx): +1 per oy0/ox0 sweep.
        if (fire) begin
            accum_d = inner_last ? '0 : accum_q + AW'(1);
            if (!ox0_last) begin
                ox0_d    = ox0_q + PW'(1);
                ox_off_d = ox_off_q + s_w;
            end else begin
                ox0_d    = '0;
                ox_off_d = '0;
                if (!oy0_last) begin
                    oy0_d    = oy0_q + PW'(1);
                    oy_off_d = oy_off_q + row_step_q;
                end else begin
                    oy0_d    = '0;
                    oy_off_d = '0;
                    weight_d = weight_q + AW'(1);
                    if (!fx_last) begin
                        fx_d = fx_q + PW'(1);
                    end else begin
                        fx_d = '0;
                        if (!fy_last) begin
                            fy_d      = fy_q + PW'(1);
                            fy_base_d = fy_base_q + ix0_q;
                        end else begin
                            fy_d      = '0;
                            fy_base_d = '0;
                            if (!ic1_last) begin
                                ic1_d     = ic1_q + PW'(1);
                                ic_base_d = ic_base_q + plane_q;
                            end else begin
                                ic1_d     = '0;
                                ic_base_d = '0;
                            end
                        end
                    end
                end
            end
        end

        if (state_q == S_DRAIN) begin
            drain_d = drain_q + DW'(1);
            if (drain_end) begin
                drain_d = '0;
                if (!oc1_last) begin
                    oc1_d = oc1_q + PW'(1);
                end else begin
                    oc1_d    = '0;
                    weight_d = '0;
                    if (!tile_last) begin
                        need_ifmap_d = 1'b1;
                        if (!ox1_last) begin
                            ox1_d = ox1_q + PW'(1);
                        end else begin
                            ox1_d = '0;
                            oy1_d = oy1_q + PW'(1);
                        end
                    end
                end
            end
        end

        ifmap_d = ic_base_d + fy_base_d + AW'(fx_d) + oy_off_d + ox_off_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            params_q      <= '0;
            ix0_q         <= '0;
            plane_q       <= '0;
            row_step_q    <= '0;
            ox0_q         <= '0;
            oy0_q         <= '0;
            fx_q          <= '0;
            fy_q          <= '0;
            ic1_q         <= '0;
            oc1_q         <= '0;
            ox1_q         <= '0;
            oy1_q         <= '0;
            ox_off_q      <= '0;
            oy_off_q      <= '0;
            fy_base_q     <= '0;
            ic_base_q     <= '0;
            ifmap_q       <= '0;
            weight_q      <= '0;
            accum_q       <= '0;
            drain_q       <= '0;
            need_ifmap_q  <= 1'b0;
            need_weight_q <= 1'b0;
        end else begin
            params_q      <= params_d;
            ix0_q         <= ix0_d;
            plane_q       <= plane_d;
            row_step_q    <= row_step_d;
            ox0_q         <= ox0_d;
            oy0_q         <= oy0_d;
            fx_q          <= fx_d;
            fy_q          <= fy_d;
            ic1_q         <= ic1_d;
            oc1_q         <= oc1_d;
            ox1_q         <= ox1_d;
            oy1_q         <= oy1_d;
            ox_off_q      <= ox_off_d;
            oy_off_q      <= oy_off_d;
            fy_base_q     <= fy_base_d;
            ic_base_q     <= ic_base_d;
            ifmap_q       <= ifmap_d;
            weight_q      <= weight_d;
            accum_q       <= accum_d;
            drain_q       <= drain_d;
            need_ifmap_q  <= need_ifmap_d;
            need_weight_q <= need_weight_d;
        end
    end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed bench for conv_loop_sequencer: address sequences, stalls,
// multi-pass bank handshakes, config rejection and mid-layer reset.
module tb_conv_loop_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [143:0] params_dat;
    logic         params_vld, params_rdy;
    logic         ifmap_bank_vld, weight_bank_vld, accum_bank_free;
    logic         ifmap_bank_done, weight_bank_done, accum_bank_done;
    logic         step_vld, step_rdy;
    logic [31:0]  ifmap_addr, weight_addr, accum_addr;
    logic         accum_zero, layer_done, layer_err;

    always #5 clk = ~clk;

    conv_loop_sequencer dut (
        .clk(clk), .rst(rst),
        .params_dat(params_dat), .params_vld(params_vld),
        .params_rdy(params_rdy),
        .ifmap_bank_vld(ifmap_bank_vld),
        .weight_bank_vld(weight_bank_vld),
        .accum_bank_free(accum_bank_free),
        .ifmap_bank_done(ifmap_bank_done),
        .weight_bank_done(weight_bank_done),
        .accum_bank_done(accum_bank_done),
        .step_vld(step_vld), .step_rdy(step_rdy),
        .ifmap_addr(ifmap_addr), .weight_addr(weight_addr),
        .accum_addr(accum_addr), .accum_zero(accum_zero),
        .layer_done(layer_done), .layer_err(layer_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_if[$], obs_w[$], obs_a[$];
    logic        obs_z[$];
    logic [31:0] exp_if[$], exp_w[$], exp_a[$];
    logic        exp_z[$];
    int n_acc, n_ifd, n_wd, n_ld, n_err, in_wait, stall_chg, stalls;
    int first_step, done_cyc;
    bit timed_out;

    function automatic logic [143:0] pack(input int oy1, ox1, oc1, ic1,
                                          fy, fx, oy0, ox0, s);
        return {16'(oy1), 16'(ox1), 16'(oc1), 16'(ic1), 16'(fy),
                16'(fx), 16'(oy0), 16'(ox0), 16'(s)};
    endfunction

    task automatic build_expected(input int oy1, ox1, oc1, ic1,
                                  fy, fx, oy0, ox0, s);
        int iy0, ix0;
        iy0 = s * (oy0 - 1) + fy;
        ix0 = s * (ox0 - 1) + fx;
        exp_if.delete(); exp_w.delete(); exp_a.delete(); exp_z.delete();
        for (int a = 0; a < oy1; a++)
        for (int b = 0; b < ox1; b++)
        for (int c = 0; c < oc1; c++)
        for (int d = 0; d < ic1; d++)
        for (int e = 0; e < fy; e++)
        for (int f = 0; f < fx; f++)
        for (int g = 0; g < oy0; g++)
        for (int h = 0; h < ox0; h++) begin
            exp_if.push_back(32'(d * iy0 * ix0 + (g * s + e) * ix0 + h * s + f));
            exp_w.push_back(32'(((c * ic1 + d) * fy + e) * fx + f));
            exp_a.push_back(32'(g * ox0 + h));
            exp_z.push_back(d == 0 && e == 0 && f == 0);
        end
    endtask

    task automatic run_layer(input logic [143:0] cfg, input bit toggle,
                             input int hold, input int max_cyc);
        int cyc, hold_cnt;
        bit done, held, acc_seen;
        logic [31:0] h_if, h_w, h_a;
        obs_if.delete(); obs_w.delete(); obs_a.delete(); obs_z.delete();
        n_acc = 0; n_ifd = 0; n_wd = 0; n_ld = 0; n_err = 0;
        in_wait = 0; stall_chg = 0; stalls = 0;
        first_step = -1; done_cyc = -1;
        ifmap_bank_vld = 1'b1; weight_bank_vld = 1'b1;
        accum_bank_free = 1'b1; step_rdy = 1'b1;
        params_dat = cfg; params_vld = 1'b1;
        @(posedge clk); #1;
        params_vld = 1'b0;
        cyc = 0; hold_cnt = 0; done = 0; held = 0;
        h_if = '0; h_w = '0; h_a = '0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            if (held && (step_vld !== 1'b1 || ifmap_addr !== h_if ||
                         weight_addr !== h_w || accum_addr !== h_a))
                stall_chg++;
            if (step_vld && step_rdy) begin
                obs_if.push_back(ifmap_addr);
                obs_w.push_back(weight_addr);
                obs_a.push_back(accum_addr);
                obs_z.push_back(accum_zero);
                if (first_step < 0) first_step = cyc;
            end
            if (step_vld && !accum_bank_free) in_wait++;
            held = step_vld && !step_rdy;
            if (held) stalls++;
            h_if = ifmap_addr; h_w = weight_addr; h_a = accum_addr;
            acc_seen = accum_bank_done;
            n_acc += int'(accum_bank_done);
            n_ifd += int'(ifmap_bank_done);
            n_wd  += int'(weight_bank_done);
            n_err += int'(layer_err);
            if (layer_done) begin
                n_ld++; done_cyc = cyc; done = 1;
            end
            if (layer_err) done = 1;
            @(posedge clk); #1;
            if (toggle) step_rdy = ~step_rdy;
            if (acc_seen && hold > 0) hold_cnt = hold;
            else if (hold_cnt > 0) hold_cnt--;
            accum_bank_free = (hold_cnt == 0);
            cyc++;
        end
        timed_out = !done;
        step_rdy = 1'b1; accum_bank_free = 1'b1;
    endtask

    task automatic cmp_steps(input string tag);
        checks++;
        if (obs_if.size() !== exp_if.size()) begin
            errors++;
            $display("FAIL %s step_count got %0d exp %0d", tag,
                     obs_if.size(), exp_if.size());
        end
        for (int i = 0; i < obs_if.size() && i < exp_if.size(); i++) begin
            checks++;
            if (obs_if[i] !== exp_if[i] || obs_w[i] !== exp_w[i] ||
                obs_a[i] !== exp_a[i] || obs_z[i] !== exp_z[i]) begin
                errors++;
                $display("FAIL %s step%0d got if=%0d w=%0d a=%0d z=%0d exp if=%0d w=%0d a=%0d z=%0d",
                         tag, i, obs_if[i], obs_w[i], obs_a[i], obs_z[i],
                         exp_if[i], exp_w[i], exp_a[i], exp_z[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; params_vld = 1'b0; params_dat = '0; step_rdy = 1'b0;
        ifmap_bank_vld = 1'b0; weight_bank_vld = 1'b0; accum_bank_free = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (params_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_rdy got %b exp 1", params_rdy);
        end
        checks++;
        if ({step_vld, accum_zero, ifmap_bank_done, weight_bank_done,
             accum_bank_done, layer_done, layer_err} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0",
                {step_vld, accum_zero, ifmap_bank_done, weight_bank_done,
                 accum_bank_done, layer_done, layer_err});
        end
        checks++;
        if ({ifmap_addr, weight_addr, accum_addr} !== 96'b0) begin
            errors++; $display("FAIL reset_addr got %0d %0d %0d exp 0",
                               ifmap_addr, weight_addr, accum_addr);
        end
    endtask

    task automatic test_min_layer(input string tag);
        run_layer(pack(1, 1, 1, 1, 1, 1, 1, 1, 1), 0, 0, 200);
        checks++;
        if (timed_out || n_ld !== 1 || n_acc !== 1 || n_ifd !== 1 || n_wd !== 1) begin
            errors++;
            $display("FAIL %s pulses got to=%0d ld=%0d acc=%0d ifd=%0d wd=%0d exp 0 1 1 1 1",
                     tag, timed_out, n_ld, n_acc, n_ifd, n_wd);
        end
        checks++;
        if (obs_if.size() !== 1) begin
            errors++; $display("FAIL %s steps got %0d exp 1", tag, obs_if.size());
        end else begin
            checks++;
            if (obs_if[0] !== 0 || obs_w[0] !== 0 || obs_a[0] !== 0 || obs_z[0] !== 1'b1) begin
                errors++;
                $display("FAIL %s step0 got %0d %0d %0d z=%0d exp 0 0 0 z=1",
                         tag, obs_if[0], obs_w[0], obs_a[0], obs_z[0]);
            end
        end
        checks++;
        if (done_cyc - first_step < 8 || done_cyc - first_step > 11) begin
            errors++;
            $display("FAIL %s latency got %0d exp 8..11", tag, done_cyc - first_step);
        end
        @(negedge clk);
        checks++;
        if (params_rdy !== 1'b1) begin
            errors++; $display("FAIL %s rdy_after got %b exp 1", tag, params_rdy);
        end
    endtask

    task automatic test_rect_layer;
        build_expected(1, 1, 1, 2, 3, 3, 2, 3, 2);
        run_layer(pack(1, 1, 1, 2, 3, 3, 2, 3, 2), 0, 0, 400);
        checks++;
        if (timed_out || n_acc !== 1 || n_ld !== 1) begin
            errors++;
            $display("FAIL rect_done got to=%0d acc=%0d ld=%0d exp 0 1 1",
                     timed_out, n_acc, n_ld);
        end
        cmp_steps("rect");
        checks++;
        if (obs_if.size() !== 108) begin
            errors++; $display("FAIL rect_n got %0d exp 108", obs_if.size());
        end else begin
            checks++;
            if (obs_if[54] !== 35 || obs_z[54] !== 1'b0 || obs_z[0] !== 1'b1) begin
                errors++;
                $display("FAIL rect_ic1 got if=%0d z54=%0d z0=%0d exp 35 0 1",
                         obs_if[54], obs_z[54], obs_z[0]);
            end
            checks++;
            if (obs_if[3] !== 14 || obs_if[107] !== 69 || obs_w[107] !== 17) begin
                errors++;
                $display("FAIL rect_rows got if3=%0d if107=%0d w107=%0d exp 14 69 17",
                         obs_if[3], obs_if[107], obs_w[107]);
            end
        end
    endtask

    task automatic test_stall;
        build_expected(1, 1, 1, 2, 3, 3, 2, 3, 2);
        run_layer(pack(1, 1, 1, 2, 3, 3, 2, 3, 2), 1, 0, 800);
        checks++;
        if (timed_out || n_ld !== 1) begin
            errors++; $display("FAIL stall_done got to=%0d ld=%0d exp 0 1", timed_out, n_ld);
        end
        cmp_steps("stall");
        checks++;
        if (stall_chg !== 0 || stalls < 50) begin
            errors++;
            $display("FAIL stall_hold got changes=%0d stalls=%0d exp 0 >=50",
                     stall_chg, stalls);
        end
    endtask

    task automatic test_multi_pass;
        build_expected(1, 2, 3, 1, 1, 1, 1, 2, 1);
        run_layer(pack(1, 2, 3, 1, 1, 1, 1, 2, 1), 0, 20, 2000);
        checks++;
        if (timed_out || n_acc !== 6 || n_ifd !== 2 || n_wd !== 1 || n_ld !== 1) begin
            errors++;
            $display("FAIL multi_pulses got to=%0d acc=%0d ifd=%0d wd=%0d ld=%0d exp 0 6 2 1 1",
                     timed_out, n_acc, n_ifd, n_wd, n_ld);
        end
        checks++;
        if (in_wait !== 0) begin
            errors++; $display("FAIL multi_wait got %0d exp 0", in_wait);
        end
        cmp_steps("multi");
    endtask

    task automatic test_err;
        int bad_steps;
        bad_steps = 0;
        params_dat = pack(1, 1, 1, 1, 0, 1, 1, 1, 1);
        params_vld = 1'b1;
        @(posedge clk); #1;
        params_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (layer_err !== 1'b1 || params_rdy !== 1'b0 || step_vld !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got err=%b rdy=%b vld=%b exp 1 0 0",
                     layer_err, params_rdy, step_vld);
        end
        @(negedge clk);
        checks++;
        if (params_rdy !== 1'b1 || layer_err !== 1'b0) begin
            errors++;
            $display("FAIL err_back got rdy=%b err=%b exp 1 0", params_rdy, layer_err);
        end
        repeat (5) begin
            @(negedge clk);
            if (step_vld) bad_steps++;
        end
        checks++;
        if (bad_steps !== 0) begin
            errors++; $display("FAIL err_steps got %0d exp 0", bad_steps);
        end
    endtask

    task automatic test_reset_mid;
        int fired, pulses, cyc;
        fired = 0; pulses = 0; cyc = 0;
        ifmap_bank_vld = 1'b1; weight_bank_vld = 1'b1;
        accum_bank_free = 1'b1; step_rdy = 1'b1;
        params_dat = pack(1, 1, 1, 2, 3, 3, 2, 3, 2);
        params_vld = 1'b1;
        @(posedge clk); #1;
        params_vld = 1'b0;
        while (fired < 20 && cyc < 100) begin
            @(negedge clk);
            if (step_vld && step_rdy) fired++;
            cyc++;
        end
        checks++;
        if (fired !== 20) begin
            errors++; $display("FAIL rstmid_run got %0d exp 20", fired);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(accum_bank_done) + int'(ifmap_bank_done) +
                      int'(weight_bank_done) + int'(layer_done);
        end
        checks++;
        if (step_vld !== 1'b0 || params_rdy !== 1'b1 || pulses !== 0) begin
            errors++;
            $display("FAIL rstmid_idle got vld=%b rdy=%b pulses=%0d exp 0 1 0",
                     step_vld, params_rdy, pulses);
        end
        test_min_layer("after_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_min_layer("min");
        test_rect_layer();
        test_stall();
        test_multi_pass();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
